// File: rtl/lib_pkg.sv
// Shared ALU operation selector plus RV32I opcode and funct7 constants
// used by the ALU issue path.
package lib_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_type_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Base funct3 map shared by OP and OP-IMM; the alternate forms are applied by the caller.
  function automatic alu_type_t f3_to_alu(input logic [2:0] f3);
    alu_type_t t;
    case (f3)
      3'b000:  t = ALU_ADD;
      3'b001:  t = ALU_SLL;
      3'b010:  t = ALU_SLT;
      3'b011:  t = ALU_SLTU;
      3'b100:  t = ALU_XOR;
      3'b101:  t = ALU_SRL;
      3'b110:  t = ALU_OR;
      default: t = ALU_AND;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/alu_issue_decode_comb.sv
// Pure combinational RV32I ALU-class decode: operation, operands,
// destination and legality for one instruction word.
module alu_issue_decode_comb
  import lib_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output alu_type_t        alu_type_c,
  output logic [WIDTH-1:0] in0_c,
  output logic [WIDTH-1:0] in1_c,
  output logic [4:0]       rd_c,
  output logic             rd_we_c,
  output logic             illegal_c
);

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] imm_u;
  logic [WIDTH-1:0] shamt;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = WIDTH'($signed(instr[31:20]));
  assign imm_u  = WIDTH'({instr[31:12], 12'b0});
  assign shamt  = WIDTH'(instr[24:20]);

  logic             legal;
  alu_type_t        op_sel;
  logic [WIDTH-1:0] op_in0;
  logic [WIDTH-1:0] op_in1;

  // Classify the word; legality gates every output below.
  always_comb begin
    legal  = 1'b0;
    op_sel = ALU_ADD;
    op_in0 = '0;
    op_in1 = '0;
    case (opcode)
      OPC_OP: begin
        op_in0 = rs1_data;
        op_in1 = rs2_data;
        if (f7 == F7_BASE) begin
          legal  = 1'b1;
          op_sel = f3_to_alu(f3);
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          legal  = 1'b1;
          op_sel = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        op_in0 = rs1_data;
        op_in1 = imm_i;
        op_sel = f3_to_alu(f3);
        legal  = 1'b1;
        if (f3 == 3'b001) begin
          op_in1 = shamt;
          legal  = (f7 == F7_BASE);
        end else if (f3 == 3'b101) begin
          op_in1 = shamt;
          legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
          if (f7 == F7_ALT) op_sel = ALU_SRA;
        end
      end
      OPC_LUI: begin
        legal  = 1'b1;
        op_in1 = imm_u;
      end
      OPC_AUIPC: begin
        legal  = 1'b1;
        op_in0 = pc;
        op_in1 = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  assign illegal_c  = !legal;
  assign alu_type_c = legal ? op_sel : ALU_ADD;
  assign in0_c      = legal ? op_in0 : '0;
  assign in1_c      = legal ? op_in1 : '0;
  assign rd_c       = legal ? instr[11:7] : 5'd0;
  assign rd_we_c    = legal;

endmodule

// File: rtl/alu_issue_decoder.sv
// Single-entry ALU issue register: accepts a fetched word, decodes it and
// holds the operation until the ALU stage takes it; counts illegal issues.
module alu_issue_decoder
  import lib_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output alu_type_t        alu_type,
  output logic [WIDTH-1:0] in0,
  output logic [WIDTH-1:0] in1,
  output logic [4:0]       rd,
  output logic             rd_we,
  output logic             illegal,
  output logic [15:0]      illegal_cnt
);

  localparam int unsigned CNT_W = 16;

  alu_type_t        dec_alu_type_c;
  logic [WIDTH-1:0] dec_in0_c;
  logic [WIDTH-1:0] dec_in1_c;
  logic [4:0]       dec_rd_c;
  logic             dec_rd_we_c;
  logic             dec_illegal_c;

  alu_issue_decode_comb #(.WIDTH(WIDTH)) u_decode (
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .alu_type_c (dec_alu_type_c),
    .in0_c      (dec_in0_c),
    .in1_c      (dec_in1_c),
    .rd_c       (dec_rd_c),
    .rd_we_c    (dec_rd_we_c),
    .illegal_c  (dec_illegal_c)
  );

  logic             out_valid_q, out_valid_d;
  alu_type_t        alu_type_q,  alu_type_d;
  logic [WIDTH-1:0] in0_q,       in0_d;
  logic [WIDTH-1:0] in1_q,       in1_d;
  logic [4:0]       rd_q,        rd_d;
  logic             rd_we_q,     rd_we_d;
  logic             illegal_q,   illegal_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             capture;

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready;
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  // A capture in the same cycle as a handshake replaces the held entry.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_type_d  = alu_type_q;
    in0_d       = in0_q;
    in1_d       = in1_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    if (capture) begin
      out_valid_d = 1'b1;
      alu_type_d  = dec_alu_type_c;
      in0_d       = dec_in0_c;
      in1_d       = dec_in1_c;
      rd_d        = dec_rd_c;
      rd_we_d     = dec_rd_we_c;
      illegal_d   = dec_illegal_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (out_valid_q && out_ready && illegal_q && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_type_q  <= ALU_ADD;
      in0_q       <= '0;
      in1_q       <= '0;
      rd_q        <= 5'd0;
      rd_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_type_q  <= alu_type_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_type    = alu_type_q;
  assign in0         = in0_q;
  assign in1         = in1_q;
  assign rd          = rd_q;
  assign rd_we       = rd_we_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed bench for alu_issue_decoder: a behavioural issue-slot model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_alu_issue_decoder;
  import lib_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  alu_type_t   alu_type;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;
  logic [15:0] illegal_cnt;

  alu_issue_decoder #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .pc          (pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_type    (alu_type),
    .in0         (in0),
    .in1         (in1),
    .rd          (rd),
    .rd_we       (rd_we),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    alu_type_t   alu;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  // What the issue slot must hold for a word, straight from the RV32I rules.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    alu_type_t tbl [8];
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok, shift;
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3 = w[14:12];
    f7 = w[31:25];
    e = '0;
    e.alu = ALU_ADD;
    ok = 1'b0;
    case (w[6:0])
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.alu = (f7 == 7'h20) ? ((f3 == 3'd0) ? ALU_SUB : ALU_SRA) : tbl[f3];
        e.in0 = a;
        e.in1 = b;
      end
      7'h13: begin
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        ok = !shift || (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
        e.alu = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : tbl[f3];
        e.in0 = a;
        e.in1 = shift ? {27'b0, w[24:20]} : {{20{w[31]}}, w[31:20]};
      end
      7'h37: begin ok = 1'b1; e.in0 = 32'h0; e.in1 = {w[31:12], 12'h000}; end
      7'h17: begin ok = 1'b1; e.in0 = p;     e.in1 = {w[31:12], 12'h000}; end
      default: ok = 1'b0;
    endcase
    if (ok) begin
      e.rd = w[11:7];
      e.we = 1'b1;
    end else begin
      e = '0;
      e.alu = ALU_ADD;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Reference issue slot and illegal counter.
  logic        m_valid;
  exp_t        m_e;
  logic [15:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_cnt   <= 16'd0;
    end else begin
      if (m_valid && out_ready && m_e.ill && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      if (in_valid && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_e     <= model(instr, pc, rs1_data, rs2_data);
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk("rs1_addr", 32'(rs1_addr), 32'(instr[19:15]));
      chk("rs2_addr", 32'(rs2_addr), 32'(instr[24:20]));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
      if (m_valid) begin
        chk("alu_type", 32'(alu_type), 32'(m_e.alu));
        chk("in0", in0, m_e.in0);
        chk("in1", in1, m_e.in1);
        chk("rd_we", 32'(rd_we), 32'(m_e.we));
        chk("illegal", 32'(illegal), 32'(m_e.ill));
        if (!m_e.ill) chk("rd", 32'(rd), 32'(m_e.rd));
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b, input logic ordy);
    in_valid  = v;
    instr     = w;
    pc        = p;
    rs1_data  = a;
    rs2_data  = b;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; instr = 32'h0; pc = 32'h0;
    rs1_data = 32'h0; rs2_data = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst rd_we", 32'(rd_we), 32'd0);
    chk("rst rd", 32'(rd), 32'd0);
    chk("rst alu_type", 32'(alu_type), 32'(ALU_ADD));
    chk("rst in0", in0, 32'd0);
    chk("rst in1", in1, 32'd0);
    chk("rst cnt", 32'(illegal_cnt), 32'd0);
    rst_n = 1'b1;

    step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1);
    chk("add valid", 32'(out_valid), 32'd1);
    chk("add alu", 32'(alu_type), 32'(ALU_ADD));
    chk("add in0", in0, 32'd5);
    chk("add in1", in1, 32'd7);
    chk("add rd", 32'(rd), 32'd3);
    chk("add rd_we", 32'(rd_we), 32'd1);

    step(1'b1, 32'h402081B3, 32'h0, 32'd9, 32'd4, 1'b1);
    chk("sub alu", 32'(alu_type), 32'(ALU_SUB));

    step(1'b1, 32'h40335293, 32'h0, 32'h8000_0000, 32'd0, 1'b1);
    chk("srai alu", 32'(alu_type), 32'(ALU_SRA));
    chk("srai in1", in1, 32'd3);
    chk("srai rd", 32'(rd), 32'd5);

    step(1'b1, 32'hFFF00093, 32'h0, 32'd0, 32'd0, 1'b1);
    chk("addi in1", in1, 32'hFFFF_FFFF);

    step(1'b1, 32'h12345137, 32'h0, 32'hDEAD_BEEF, 32'd0, 1'b1);
    chk("lui in0", in0, 32'h0);
    chk("lui in1", in1, 32'h1234_5000);
    chk("lui rd", 32'(rd), 32'd2);

    step(1'b1, 32'h00001217, 32'h100, 32'd0, 32'd0, 1'b1);
    chk("auipc in0", in0, 32'h100);
    chk("auipc in1", in1, 32'h1000);

    step(1'b1, 32'h022081B3, 32'h0, 32'd5, 32'd7, 1'b1);
    chk("mul illegal", 32'(illegal), 32'd1);
    chk("mul rd_we", 32'(rd_we), 32'd0);
    chk("mul in0", in0, 32'd0);
    step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1);
    chk("mul cnt", 32'(illegal_cnt), 32'd1);
    chk("drained", 32'(out_valid), 32'd0);

    // Backpressure: word A held while B waits, then B replaces A on release.
    step(1'b1, 32'h005201B3, 32'h0, 32'd11, 32'd22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0062F233, 32'h0, 32'd100, 32'hF0, 1'b0);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp in0", in0, 32'd11);
      chk("bp rd", 32'(rd), 32'd3);
    end
    step(1'b1, 32'h0062F233, 32'h0, 32'd100, 32'hF0, 1'b1);
    chk("b alu", 32'(alu_type), 32'(ALU_AND));
    chk("b in0", in0, 32'd100);
    chk("b rd", 32'(rd), 32'd4);

    step(1'b1, 32'h402091B3, 32'h0, 32'd1, 32'd2, 1'b1);
    chk("op alt sll illegal", 32'(illegal), 32'd1);
    step(1'b1, 32'h40009093, 32'h0, 32'd1, 32'd2, 1'b1);
    chk("slli alt illegal", 32'(illegal), 32'd1);
    step(1'b1, 32'hFFF0B393, 32'h0, 32'd1, 32'd0, 1'b1);
    chk("sltiu alu", 32'(alu_type), 32'(ALU_SLTU));
    chk("sltiu in1", in1, 32'hFFFF_FFFF);
    chk("sltiu rd", 32'(rd), 32'd7);
    step(1'b1, 32'h0000_0000, 32'h0, 32'd1, 32'd2, 1'b1);
    chk("opc0 illegal", 32'(illegal), 32'd1);
    step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1);
    chk("cnt four", 32'(illegal_cnt), 32'd4);

    // Reset while an operation is held and not taken.
    step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst cnt", 32'(illegal_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 32'h002081B3, 32'h0, 32'd3, 32'd4, 1'b1);
    chk("post rst valid", 32'(out_valid), 32'd1);
    chk("post rst in0", in0, 32'd3);
    step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_decoder.md
ALU_ISSUE_DECODER -- requirements
Module: alu_issue_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath and operand width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch word valid.
- in_ready  out  1  decoder can accept a word.
- instr  in  32  RV32I instruction word.
- pc  in  WIDTH  address of instr.
- rs1_addr, rs2_addr  out  5 each  register-file read addresses, combinational from instr[19:15] and instr[24:20].
- rs1_data, rs2_data  in  WIDTH each  register-file read data, valid in the same cycle.
- out_valid  out  1  issue slot holds an operation.
- out_ready  in  1  ALU stage accepts the operation.
- alu_type  out  alu_type_t  operation selector for the ALU.
- in0, in1  out  WIDTH each  ALU operands.
- rd  out  5  destination register.
- rd_we  out  1  write-enable for the result.
- illegal  out  1  the held operation is not decodable.
- illegal_cnt  out  16  count of illegal words issued.

Function
REQ-003 SHALL implement a single-entry output register: in_ready = !out_valid || out_ready, combinational.
REQ-004 SHALL capture on in_valid && in_ready; captured values appear on outputs the next cycle, giving one-cycle latency.
REQ-005 SHALL clear out_valid on out_ready && out_valid unless a new word is captured in the same cycle.
REQ-006 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-007 SHALL decode OP (0110011) from funct3 as follows:
- 000: ADD, or SUB when funct7=0100000.
- 001: SLL.
- 010: SLT.
- 011: SLTU.
- 100: XOR.
- 101: SRL, or SRA when funct7=0100000.
- 110: OR.
- 111: AND.
- Operands: in0=rs1_data, in1=rs2_data.
REQ-008 SHALL mark OP illegal for funct7 not in {0000000, 0100000}, and for funct7=0100000 with funct3 not in {000, 101}.
REQ-009 SHALL decode OP-IMM (0010011) with the same funct3 map, except funct3=000 is always ADD:
- Operands: in0=rs1_data, in1=sign-extended I-immediate.
- SLLI requires instr[31:25]=0000000.
- SRLI/SRAI require instr[31:25] in {0000000, 0100000}.
- Any other instr[31:25] on a shift is illegal.
REQ-010 SHALL decode LUI (0110111) as ADD with in0=0 and in1={instr[31:12],12'b0}.
REQ-011 SHALL decode AUIPC (0010111) as ADD with in0=pc and in1={instr[31:12],12'b0}.
REQ-012 SHALL set rd=instr[11:7] and rd_we=1 for every legal operation.
REQ-013 SHALL issue any other opcode, or any illegal encoding, with out_valid=1, illegal=1, alu_type=ADD, in0=in1=0, rd_we=0.
REQ-014 SHALL increment illegal_cnt by 1 on each handshake (out_valid && out_ready) where illegal=1, saturating at 16'hFFFF.
REQ-015 SHALL treat a simultaneous handshake on both sides in one cycle as a replace: no bubble, no dropped word.

Reset
REQ-016 SHALL on rst_n low, asynchronously set:
- out_valid=0, illegal=0, rd_we=0.
- rd=0, alu_type=ADD.
- in0=in1=0, illegal_cnt=0.
REQ-017 SHALL discard an un-handshaken held operation when reset is asserted mid-operation, and SHALL accept input in the first cycle after deassertion.

Structure
REQ-018 SHALL take alu_type_t from lib_pkg; opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC) and the funct7 constants SHALL be added to lib_pkg.
REQ-019 SHALL place pure combinational decode in one sub-module, alu_issue_decode_comb; the top holds only the handshake register and the counter.

Verification
REQ-020 SHALL cover the scenarios below:
- instr=0x002081B3, rs1_data=5, rs2_data=7, out_ready=1 -> next cycle: ADD, in0=5, in1=7, rd=3, rd_we=1.
- instr=0x402081B3 -> SUB; instr=0x40335293 -> SRA, in1=3, rd=5; instr=0xFFF00093 -> ADD, in1=32'hFFFFFFFF.
- instr=0x12345137 -> ADD, in0=0, in1=32'h12345000, rd=2; AUIPC with pc=32'h100 -> in0=32'h100.
- instr=0x022081B3 (MUL) -> illegal=1, rd_we=0; after handshake, illegal_cnt=1.
- out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, second word accepted in the cycle out_ready rises, no loss.
- rst_n pulsed low while out_valid=1 -> out_valid=0 immediately, illegal_cnt=0.
